// File: rtl/param_sync_counter.sv
// rtl/param_sync_counter.sv - parameterised synchronous up/down counter with load, wrap/saturate and cascade outputs; optional match port under PARAM_SYNC_COUNTER_MATCH_EN
module param_sync_counter #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef PARAM_SYNC_COUNTER_MATCH_EN
    input  logic [WIDTH-1:0] match_val,
    output logic             match,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             co
);

    // Largest reachable count. When MODULUS == 2**WIDTH this is all-ones and
    // the wrap paths below collapse onto natural binary overflow.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Reject configurations the count range cannot represent.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("param_sync_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("param_sync_counter: MODULUS must be 2..2**WIDTH");
    end

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] count_next;

    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);

    // Terminal count follows up_dn directly so a direction change is seen at once.
    assign tc = up_dn ? at_max : at_zero;

    // Carry only when this edge would actually step the counter; the next
    // stage uses it as its enable, so load and reset must suppress it.
    assign co = tc & en & ~load & ~rst;

    // Out-of-range load values are pinned to the top of the count range.
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Boundary handling: wrap to the opposite end, or hold when saturating.
    assign count_inc = at_max  ? (SATURATE ? count : '0)      : count + ONE;
    assign count_dec = at_zero ? (SATURATE ? count : MAX_VAL) : count - ONE;

    // Next-state selection in priority order: reset, load, count, hold.
    always_comb begin
        count_next = count;
        if (rst) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_clamped;
        end else if (en) begin
            count_next = up_dn ? count_inc : count_dec;
        end
    end

    // Single register bank on one clock edge; reset is folded into count_next.
    always_ff @(posedge clk) begin
        count <= count_next;
    end

`ifdef PARAM_SYNC_COUNTER_MATCH_EN
    // Pulse when the count moves onto match_val; sitting at the value, or
    // reloading the value already held, does not retrigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            match <= 1'b0;
        end else begin
            match <= (count_next != count) && (count_next == match_val);
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_counter.sv
// tb/tb_param_sync_counter.sv - directed bench for param_sync_counter
module tb_param_sync_counter;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] count_w, count_s, count_f;
    logic       tc_w, tc_s, tc_f;
    logic       co_w, co_s, co_f;

    logic       en_c;
    logic       up_c   = 1'b1;
    logic       zero_b = 1'b0;
    logic [3:0] zero_v = 4'd0;
    logic [3:0] count_c0, count_c1;
    logic       tc_c0, tc_c1, co_c0, co_c1;

`ifdef PARAM_SYNC_COUNTER_MATCH_EN
    logic [3:0] match_val = 4'd5;
    logic       match_w, match_s, match_f, match_c0, match_c1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef PARAM_SYNC_COUNTER_MATCH_EN
        .match_val(match_val), .match(match_w),
`endif
        .count(count_w), .tc(tc_w), .co(co_w));

    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef PARAM_SYNC_COUNTER_MATCH_EN
        .match_val(match_val), .match(match_s),
`endif
        .count(count_s), .tc(tc_s), .co(co_s));

    param_sync_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_full (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef PARAM_SYNC_COUNTER_MATCH_EN
        .match_val(match_val), .match(match_f),
`endif
        .count(count_f), .tc(tc_f), .co(co_f));

    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c0 (
        .clk(clk), .rst(rst), .en(en_c), .up_dn(up_c), .load(zero_b), .load_val(zero_v),
`ifdef PARAM_SYNC_COUNTER_MATCH_EN
        .match_val(match_val), .match(match_c0),
`endif
        .count(count_c0), .tc(tc_c0), .co(co_c0));

    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c1 (
        .clk(clk), .rst(rst), .en(co_c0), .up_dn(up_c), .load(zero_b), .load_val(zero_v),
`ifdef PARAM_SYNC_COUNTER_MATCH_EN
        .match_val(match_val), .match(match_c1),
`endif
        .count(count_c1), .tc(tc_c1), .co(co_c1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0; en_c = 1'b0;
        tick();
        tick();
        chk("reset_count_w", count_w, 0);
        chk("reset_count_s", count_s, 0);
        chk("reset_count_f", count_f, 0);
        chk("reset_tc_up", tc_w, 0);
        up_dn = 1'b0; #1;
        chk("reset_tc_dn", tc_w, 1);

        // reset applied mid-count from 7
        rst = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 4'd7;
        tick();
        chk("preload7", count_w, 7);
        load = 1'b0; en = 1'b1; rst = 1'b1;
        tick();
        chk("midreset_first_edge", count_w, 0);
        tick();
        chk("midreset_second_edge", count_w, 0);
        chk("midreset_tc_up", tc_w, 0);
        up_dn = 1'b0; #1;
        chk("midreset_tc_dn", tc_w, 1);
        chk("midreset_co_blocked", co_w, 0);

        // up count with wrap, saturate and natural overflow
        rst = 1'b0; up_dn = 1'b1; en = 1'b1; #1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("up_w_%0d", i), count_w, i % 10);
            chk($sformatf("up_co_w_%0d", i), co_w, (i % 10) == 9);
            chk($sformatf("up_s_%0d", i), count_s, (i < 9) ? i : 9);
            chk($sformatf("up_f_%0d", i), count_f, i);
`ifdef PARAM_SYNC_COUNTER_MATCH_EN
            chk($sformatf("up_match_%0d", i), match_w, i == 5);
`endif
            tick();
        end
        chk("up_end_w", count_w, 2);
        chk("up_end_s", count_s, 9);
        chk("up_end_f", count_f, 12);

        // down from 2: wrap vs saturate
        en = 1'b0; load = 1'b1; load_val = 4'd2;
        tick();
        chk("load2_w", count_w, 2);
        chk("load2_s", count_s, 2);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        chk("dn1_w", count_w, 1); chk("dn1_s", count_s, 1); chk("dn1_f", count_f, 1);
        tick();
        chk("dn2_w", count_w, 0); chk("dn2_s", count_s, 0); chk("dn2_f", count_f, 0);
        chk("dn2_co_s", co_s, 1);
        tick();
        chk("dn3_w", count_w, 9); chk("dn3_s", count_s, 0); chk("dn3_f", count_f, 15);
        chk("dn3_co_s", co_s, 1);
        tick();
        chk("dn4_w", count_w, 8); chk("dn4_s", count_s, 0); chk("dn4_f", count_f, 14);
        chk("dn4_co_s", co_s, 1);
        chk("dn4_co_w", co_w, 0);

        // load priority over counting, and clamping
        up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd6;
        tick();
        chk("load6_w", count_w, 6); chk("load6_s", count_s, 6); chk("load6_f", count_f, 6);
        load_val = 4'd15;
        tick();
        chk("load15_clamp_w", count_w, 9);
        chk("load15_clamp_s", count_s, 9);
        chk("load15_f", count_f, 15);
        chk("load_tc_w", tc_w, 1);
        chk("load_co_blocked", co_w, 0);
        load = 1'b0; #1;
        chk("co_at9", co_w, 1);
        chk("co_f_at15", co_f, 1);
        tick();
        chk("wrap_after_load_w", count_w, 0);
        chk("sat_after_load_s", count_s, 9);
        chk("overflow_f", count_f, 0);

        // hold and direction change
        en = 1'b0;
        tick();
        chk("hold_w", count_w, 0);
        chk("hold_co", co_w, 0);
        chk("tc_up_at0", tc_w, 0);
        up_dn = 1'b0; #1;
        chk("tc_dn_at0", tc_w, 1);

`ifdef PARAM_SYNC_COUNTER_MATCH_EN
        load = 1'b1; load_val = 4'd5;
        tick();
        chk("match_load_into5", match_w, 1);
        tick();
        chk("match_reload5", match_w, 0);
        load = 1'b0;
        tick();
        chk("match_hold5", match_w, 0);
`endif

        // two-digit cascade
        load = 1'b0; en = 1'b0; en_c = 1'b1; #1;
        for (int k = 0; k < 100; k++) begin
            if ((k % 10) == 0 || (k % 10) == 9) begin
                chk($sformatf("cas_lo_%0d", k), count_c0, k % 10);
                chk($sformatf("cas_hi_%0d", k), count_c1, k / 10);
            end
            tick();
        end
        chk("cas_end_lo", count_c0, 0);
        chk("cas_end_hi", count_c1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
